// File: rtl/scoreboard_pkg.sv
// Shared types for the game scoreboard: outcome code, FSM state and FIFO event record.
package scoreboard_pkg;

    // Outcome encoding shared with the counter's WHO field.
    typedef enum logic [1:0] {
        NONE   = 2'b00,
        LOSER  = 2'b01,
        WINNER = 2'b10,
        DRAW   = 2'b11
    } who_t;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    // One queued event as presented to the host/display reader.
    typedef struct packed {
        logic       over;
        logic       win;
        logic       lose;
        logic [3:0] count;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

endpackage

// File: rtl/sb_event_fifo.sv
// Small synchronous FIFO with registered storage and a valid/ready style read side.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sb_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] pop_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_q;
    logic [AW:0]       rd_q;
    logic              push_ok;
    logic              pop_ok;

    assign valid   = (wr_q != rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop && valid;
    // A push into a full FIFO still succeeds when the head leaves on the same edge.
    assign push_ok = push && (!full || pop_ok);
    // Head is forced to zero while empty so the reset-time output is all zeros.
    assign pop_data = valid ? mem[rd_q[AW-1:0]] : '0;

    // Pointer update; the only state cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/game_scoreboard.sv
// Game scoreboard: tallies winner/loser strobes, ends the game at LIMIT,
// holds the outcome until cleared and queues every accepted event.
module game_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int LIMIT = 15,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       winner_i,
    input  logic       loser_i,
    input  logic [3:0] count_i,
    input  logic       clear_i,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [6:0] evt_data_o,
    output logic [3:0] win_tally_o,
    output logic [3:0] lose_tally_o,
    output logic       gameover_o,
    output logic [1:0] who_o,
    output logic       overflow_o
);

    localparam logic [3:0] LIMIT_V = 4'(LIMIT);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] win_q;
    logic [3:0] lose_q;
    logic [3:0] win_d;
    logic [3:0] lose_d;
    who_t       who_q;
    logic       gameover_q;
    logic       overflow_q;
    logic       accept;
    logic       hit_w;
    logic       hit_l;
    logic       ends;
    logic       fifo_full;
    evt_t       push_evt;

    // Event acceptance, post-increment tallies and game-ending detection.
    always_comb begin
        accept   = (state_q == PLAY) && !clear_i && (winner_i || loser_i);
        win_d    = win_q + {3'b000, winner_i};
        lose_d   = lose_q + {3'b000, loser_i};
        hit_w    = accept && (win_d == LIMIT_V);
        hit_l    = accept && (lose_d == LIMIT_V);
        ends     = hit_w || hit_l;
        push_evt = '{over: ends, win: winner_i, lose: loser_i, count: count_i};
    end

    // Next-state logic: clear always returns to PLAY, a terminating event moves to OVER.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = PLAY;
        end else if (ends) begin
            state_d = OVER;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PLAY;
        else        state_q <= state_d;
    end

    // Tallies, outcome, game-over pulse and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            lose_q     <= '0;
            who_q      <= NONE;
            gameover_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            win_q      <= '0;
            lose_q     <= '0;
            who_q      <= NONE;
            gameover_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            gameover_q <= ends;
            if (accept) begin
                win_q  <= win_d;
                lose_q <= lose_d;
            end
            if (ends) who_q <= who_t'({hit_w, hit_l});
            // Full with no same-cycle pop means the new entry is lost.
            if (accept && fifo_full && !evt_ready_i) overflow_q <= 1'b1;
        end
    end

    sb_event_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (push_evt),
        .full      (fifo_full),
        .pop       (evt_ready_i),
        .valid     (evt_valid_o),
        .pop_data  (evt_data_o)
    );

    assign win_tally_o  = win_q;
    assign lose_tally_o = lose_q;
    assign gameover_o   = gameover_q;
    assign who_o        = who_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_game_scoreboard.sv
// Self-checking bench for game_scoreboard: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_game_scoreboard;

    localparam int LIMIT = 3;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       winner_i;
    logic       loser_i;
    logic [3:0] count_i;
    logic       clear_i;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [6:0] evt_data_o;
    logic [3:0] win_tally_o;
    logic [3:0] lose_tally_o;
    logic       gameover_o;
    logic [1:0] who_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_win;
    int         m_lose;
    int         m_who;
    bit         m_over;
    bit         m_go;
    bit         m_ovf;
    logic [6:0] m_q[$];

    game_scoreboard #(.LIMIT(LIMIT), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winner_i     (winner_i),
        .loser_i      (loser_i),
        .count_i      (count_i),
        .clear_i      (clear_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_data_o   (evt_data_o),
        .win_tally_o  (win_tally_o),
        .lose_tally_o (lose_tally_o),
        .gameover_o   (gameover_o),
        .who_o        (who_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_win = 0; m_lose = 0; m_who = 0;
        m_over = 0; m_go = 0; m_ovf = 0;
        m_q.delete();
    endtask

    // Game rules applied to the values present before the edge.
    task automatic model_edge(input bit w, input bit l, input logic [3:0] c,
                              input bit clr, input bit rdy);
        bit         pop;
        bit         push;
        logic [6:0] e;
        pop  = rdy && (m_q.size() > 0);
        push = 0;
        e    = '0;
        m_go = 0;
        if (clr) begin
            m_win = 0; m_lose = 0; m_who = 0; m_ovf = 0; m_over = 0;
        end else if (!m_over && (w || l)) begin
            m_win  += int'(w);
            m_lose += int'(l);
            if (m_win == LIMIT || m_lose == LIMIT) begin
                m_over = 1;
                m_go   = 1;
                m_who  = ((m_win == LIMIT) ? 2 : 0) + ((m_lose == LIMIT) ? 1 : 0);
            end
            push = 1;
            e    = {m_go, w, l, c};
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else                    m_ovf = 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [6:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 7'd0;
        check({tag, ".win"},   32'(win_tally_o),  m_win);
        check({tag, ".lose"},  32'(lose_tally_o), m_lose);
        check({tag, ".go"},    32'(gameover_o),   32'(m_go));
        check({tag, ".who"},   32'(who_o),        m_who);
        check({tag, ".ovf"},   32'(overflow_o),   32'(m_ovf));
        check({tag, ".valid"}, 32'(evt_valid_o),  32'(m_q.size() > 0));
        check({tag, ".data"},  32'(evt_data_o),   32'(head));
    endtask

    task automatic step(input string tag, input bit w, input bit l, input logic [3:0] c,
                        input bit clr, input bit rdy);
        winner_i    = w;
        loser_i     = l;
        count_i     = c;
        clear_i     = clr;
        evt_ready_i = rdy;
        @(posedge clk);
        #1;
        model_edge(w, l, c, clr, rdy);
        check_all(tag);
        winner_i = 0; loser_i = 0; clear_i = 0; evt_ready_i = 0;
    endtask

    initial begin
        rst_n = 0; winner_i = 0; loser_i = 0; count_i = 0; clear_i = 0; evt_ready_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_all("reset");
        rst_n = 1;

        // Three winner pulses end the game with a winner outcome.
        step("w1", 1, 0, 4'd5, 0, 0);
        step("w2", 1, 0, 4'd6, 0, 0);
        step("w3", 1, 0, 4'd7, 0, 0);
        check("w3.pulse", 32'(gameover_o), 32'd1);
        check("w3.who",   32'(who_o), 32'b10);
        step("idle1", 0, 0, 4'd0, 0, 0);
        check("idle1.pulse_gone", 32'(gameover_o), 32'd0);

        // Strobes in OVER are ignored.
        for (int i = 0; i < 5; i++) step($sformatf("over_l%0d", i), 0, 1, 4'(i), 0, 0);
        step("clear1", 0, 0, 4'd0, 1, 0);
        check("clear1.who", 32'(who_o), 32'd0);

        // Drain the three entries from the first game in order.
        for (int i = 0; i < 4; i++) step($sformatf("drain1_%0d", i), 0, 0, 4'd0, 0, 1);

        // Simultaneous strobes produce a draw.
        for (int i = 0; i < 3; i++) step($sformatf("both%0d", i), 1, 1, 4'(i + 9), 0, 1);
        check("draw.who", 32'(who_o), 32'b11);
        step("draw_idle", 0, 0, 4'd0, 0, 1);
        step("clear2", 0, 0, 4'd0, 1, 1);

        // Five events with the reader stalled: fifth entry dropped.
        step("ov0", 1, 0, 4'd1, 0, 0);
        step("ov1", 0, 1, 4'd2, 0, 0);
        step("ov2", 1, 0, 4'd3, 0, 0);
        step("ov3", 0, 1, 4'd4, 0, 0);
        step("ov4", 1, 0, 4'd5, 0, 0);
        check("ov4.flag", 32'(overflow_o), 32'd1);

        // Clear keeps FIFO contents; push and pop together while full.
        step("clear3", 0, 0, 4'd0, 1, 0);
        step("fullpp", 1, 0, 4'd8, 0, 1);
        check("fullpp.flag", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 5; i++) step($sformatf("drain2_%0d", i), 0, 0, 4'd0, 0, 1);

        // Asynchronous reset with two queued entries.
        step("clear4", 0, 0, 4'd0, 1, 0);
        step("pre_rst0", 1, 0, 4'd11, 0, 0);
        step("pre_rst1", 0, 1, 4'd12, 0, 0);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #2 rst_n = 1;
        step("post_rst", 1, 0, 4'd13, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 4'($urandom),
                 $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
